// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

    localparam int unsigned PC_W_DEF   = 10;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned LUT_IDX_W  = 4;
    localparam int unsigned LUT_OFF_W  = 11;

    localparam int unsigned START0_DEF = 0;
    localparam int unsigned START1_DEF = 256;
    localparam int unsigned START2_DEF = 512;
    localparam int unsigned START3_DEF = 768;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-decoder / lookup-table / imem signals seen by the PC sequencer.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic                 Start;
    logic [1:0]           ProgSel;
    logic                 Stall;
    logic                 BranchEn;
    logic                 Taken;
    logic [LUT_IDX_W-1:0] BrIndex;
    logic                 Halt;
    logic [LUT_IDX_W-1:0] LutIndex;
    logic [LUT_OFF_W-1:0] LutOut;
    logic [PC_W-1:0]      ProgCtr;
    logic                 Running;
    logic                 Done;
    logic [CNT_W-1:0]     InstrCount;

    modport master (
        output Start, ProgSel, Stall, BranchEn, Taken, BrIndex, Halt, LutOut,
        input  LutIndex, ProgCtr, Running, Done, InstrCount
    );

    modport slave (
        input  Start, ProgSel, Stall, BranchEn, Taken, BrIndex, Halt, LutOut,
        output LutIndex, ProgCtr, Running, Done, InstrCount
    );

endinterface

// File: rtl/instr_counter.sv
// Saturating retired-instruction counter with synchronous clear and enable.
module instr_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC register and IDLE/RUN/DONE sequencing FSM with relative branches via external LUT.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned START0 = START0_DEF,
    parameter int unsigned START1 = START1_DEF,
    parameter int unsigned START2 = START2_DEF,
    parameter int unsigned START3 = START3_DEF
) (
    input  logic           Clk,
    input  logic           Reset,
    pc_sequencer_if.slave  bus
);

    // Wide enough for both the PC and the sign-extended offset.
    localparam int unsigned SUM_W = (PC_W > LUT_OFF_W) ? PC_W : LUT_OFF_W;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] start_addr;
    logic [PC_W-1:0] br_target;
    logic [SUM_W-1:0] off_ext;
    logic            cnt_clr;
    logic            cnt_inc;

    always_comb begin
        start_addr = PC_W'(START0);
        case (bus.ProgSel)
            2'd1:    start_addr = PC_W'(START1);
            2'd2:    start_addr = PC_W'(START2);
            2'd3:    start_addr = PC_W'(START3);
            default: start_addr = PC_W'(START0);
        endcase
    end

    assign off_ext   = SUM_W'($signed(bus.LutOut));
    assign br_target = PC_W'(SUM_W'(pc_q) + off_ext);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.Start) begin
                    state_d = ST_RUN;
                    pc_d    = start_addr;
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.Stall) begin
                    state_d = ST_RUN;
                end else if (bus.Halt) begin
                    state_d = ST_DONE;
                    cnt_inc = 1'b1;
                end else if (bus.BranchEn && bus.Taken) begin
                    pc_d    = br_target;
                    cnt_inc = 1'b1;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    instr_counter #(
        .W (CNT_W)
    ) u_instr_counter (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_inc),
        .count_o (bus.InstrCount)
    );

    assign bus.LutIndex = bus.BrIndex;
    assign bus.ProgCtr  = pc_q;
    assign bus.Running  = (state_q == ST_RUN);
    assign bus.Done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized check of pc_sequencer (16-bit and 4-bit counter variants) against a behavioural model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(10), .CNT_W(16)) u_if  ();
    pc_sequencer_if #(.PC_W(10), .CNT_W(4))  u_if4 ();

    logic signed [10:0] lut [16];

    assign u_if.LutOut    = lut[u_if.LutIndex];
    assign u_if4.LutOut   = lut[u_if4.LutIndex];
    assign u_if4.Start    = u_if.Start;
    assign u_if4.ProgSel  = u_if.ProgSel;
    assign u_if4.Stall    = u_if.Stall;
    assign u_if4.BranchEn = u_if.BranchEn;
    assign u_if4.Taken    = u_if.Taken;
    assign u_if4.BrIndex  = u_if.BrIndex;
    assign u_if4.Halt     = u_if.Halt;

    pc_sequencer #(.PC_W(10), .CNT_W(16)) u_dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (u_if)
    );

    pc_sequencer #(.PC_W(10), .CNT_W(4)) u_dut4 (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (u_if4)
    );

    int errors = 0;
    int checks = 0;

    int m_pc   = 0;
    int m_cnt  = 0;
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int starts [4] = '{0, 256, 512, 768};

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: one clock edge worth of sequencer rules.
    task automatic model_edge();
        int off;
        if (!rst_n) begin
            m_pc = 0; m_cnt = 0; m_run = 1'b0; m_done = 1'b0;
        end else if (m_run) begin
            if (!u_if.Stall) begin
                m_cnt++;
                if (u_if.Halt) begin
                    m_run = 1'b0; m_done = 1'b1;
                end else if (u_if.BranchEn && u_if.Taken) begin
                    off  = int'(lut[u_if.BrIndex]);
                    m_pc = (((m_pc + off) % 1024) + 1024) % 1024;
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                end
            end
        end else if (u_if.Start) begin
            m_run = 1'b1; m_done = 1'b0;
            m_pc  = starts[u_if.ProgSel];
            m_cnt = 0;
        end
    endtask

    task automatic cycle();
        #1;
        check_eq("lut_idx", int'(u_if.LutIndex), int'(u_if.BrIndex));
        @(posedge clk);
        model_edge();
        #1;
        check_eq("pc",      int'(u_if.ProgCtr),     m_pc);
        check_eq("running", int'(u_if.Running),     int'(m_run));
        check_eq("done",    int'(u_if.Done),        int'(m_done));
        check_eq("cnt16",   int'(u_if.InstrCount),  (m_cnt > 65535) ? 65535 : m_cnt);
        check_eq("cnt4",    int'(u_if4.InstrCount), (m_cnt > 15) ? 15 : m_cnt);
        check_eq("pc4",     int'(u_if4.ProgCtr),    m_pc);
    endtask

    task automatic clear_inputs();
        u_if.Start = 1'b0; u_if.ProgSel = 2'd0; u_if.Stall = 1'b0;
        u_if.BranchEn = 1'b0; u_if.Taken = 1'b0; u_if.BrIndex = 4'd0;
        u_if.Halt = 1'b0;
    endtask

    task automatic start_prog(input int sel);
        u_if.Start = 1'b1; u_if.ProgSel = 2'(sel);
        cycle();
        u_if.Start = 1'b0;
    endtask

    task automatic halt_now();
        u_if.Halt = 1'b1;
        cycle();
        u_if.Halt = 1'b0;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lut[i] = 11'($urandom);
        lut[0] = 11'sd0;
        lut[1] = 11'sd1;
        lut[2] = 11'sd1023;
        lut[3] = -11'sd370;
        lut[4] = -11'sd1024;
        clear_inputs();

        // Reset then start program 2
        rst_n = 1'b0;
        run_n(2);
        check_eq("rst_pc", int'(u_if.ProgCtr), 0);
        check_eq("rst_done", int'(u_if.Done), 0);
        check_eq("rst_running", int'(u_if.Running), 0);
        rst_n = 1'b1;
        start_prog(2);
        check_eq("start_pc", int'(u_if.ProgCtr), 512);
        check_eq("start_running", int'(u_if.Running), 1);
        check_eq("start_cnt", int'(u_if.InstrCount), 0);

        // Five cycles, third one stalled
        for (int i = 1; i <= 5; i++) begin
            u_if.Stall = (i == 3);
            cycle();
        end
        u_if.Stall = 1'b0;
        check_eq("stall_pc", int'(u_if.ProgCtr), 516);
        check_eq("stall_cnt", int'(u_if.InstrCount), 4);

        // Backward branch wrapping below zero
        halt_now();
        start_prog(0);
        run_n(5);
        u_if.BranchEn = 1'b1; u_if.Taken = 1'b1; u_if.BrIndex = 4'd3;
        cycle();
        clear_inputs();
        check_eq("br_wrap_pc", int'(u_if.ProgCtr), 659);

        // Not-taken branch is sequential
        halt_now();
        start_prog(0);
        run_n(5);
        u_if.BranchEn = 1'b1; u_if.Taken = 1'b0; u_if.BrIndex = 4'd3;
        cycle();
        clear_inputs();
        check_eq("br_nt_pc", int'(u_if.ProgCtr), 6);

        // Halt beats taken branch; 4-bit counter saturates
        halt_now();
        start_prog(0);
        run_n(100);
        check_eq("sat_cnt4", int'(u_if4.InstrCount), 15);
        u_if.Halt = 1'b1; u_if.BranchEn = 1'b1; u_if.Taken = 1'b1; u_if.BrIndex = 4'd1;
        cycle();
        clear_inputs();
        check_eq("halt_pc", int'(u_if.ProgCtr), 100);
        check_eq("halt_done", int'(u_if.Done), 1);
        check_eq("halt_cnt", int'(u_if.InstrCount), 101);
        u_if.Stall = 1'b1;
        cycle();
        u_if.Stall = 1'b0;
        start_prog(1);
        check_eq("restart_pc", int'(u_if.ProgCtr), 256);
        check_eq("restart_cnt", int'(u_if.InstrCount), 0);

        // Sequential wrap 1023 -> 0
        halt_now();
        start_prog(3);
        run_n(256);
        check_eq("seq_wrap_pc", int'(u_if.ProgCtr), 0);

        // Reset mid-run overrides stall and start
        rst_n = 1'b0; u_if.Stall = 1'b1; u_if.Start = 1'b1;
        cycle();
        check_eq("midrst_pc", int'(u_if.ProgCtr), 0);
        check_eq("midrst_cnt", int'(u_if.InstrCount), 0);
        check_eq("midrst_running", int'(u_if.Running), 0);
        rst_n = 1'b1;
        clear_inputs();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n         = ($urandom_range(0, 127) != 0);
            u_if.Start    = ($urandom_range(0, 15) == 0);
            u_if.ProgSel  = 2'($urandom);
            u_if.Stall    = ($urandom_range(0, 3) == 0);
            u_if.Halt     = ($urandom_range(0, 40) == 0);
            u_if.BranchEn = ($urandom_range(0, 2) == 0);
            u_if.Taken    = 1'($urandom);
            u_if.BrIndex  = 4'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 3BC processor. It owns the PC register and an FSM (IDLE/RUN/DONE) that starts a selected program, advances the PC each cycle, and applies relative branches. Branch offsets come from the external branch-target lookup table (4-bit index, 11-bit signed offset); the block drives the table index and consumes its output combinationally. It also counts retired instructions for benchmarking, and sits between the control decoder and instruction memory.

## Interface
Parameters:
- PC_W, 10, PC width in bits (instruction memory depth 2^PC_W).
- CNT_W, 16, retired-instruction counter width.
- START0 / START1 / START2 / START3, 0 / 256 / 512 / 768, program start addresses selected by ProgSel.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low (0 = reset, sampled on Clk rising edge).
- Start  in  1  request to begin a program; acted on only in IDLE or DONE.
- ProgSel  in  2  selects START0..START3; sampled with Start.
- Stall  in  1  hold PC and counter this cycle.
- BranchEn  in  1  current instruction is a branch.
- Taken  in  1  branch condition true; meaningful only with BranchEn.
- BrIndex  in  4  table index from current instruction.
- Halt  in  1  current instruction is halt.
- LutIndex  out  4  to lookup table; equals BrIndex combinationally.
- LutOut  in  11  signed offset from lookup table.
- ProgCtr  out  PC_W  current PC (registered).
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.
- InstrCount  out  CNT_W  instructions retired since last Start.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, ProgCtr=0, InstrCount=0, Running=0, Done=0.
- IDLE: Start=1 → RUN, ProgCtr←START[ProgSel], InstrCount←0. All other inputs are ignored.
- RUN: per-cycle priority, highest first:
  1. Stall=1: hold PC, counter and state.
  2. Halt=1: → DONE. Hold PC. InstrCount+1 (the halt retires).
  3. BranchEn & Taken: PC←PC + sext(LutOut), truncated to PC_W (modulo 2^PC_W, wrap both directions). InstrCount+1.
  4. Otherwise: PC←PC+1 (wraps 2^PC_W−1 → 0). InstrCount+1.
- BranchEn=1 with Taken=0 behaves as sequential.
- Start is ignored in RUN.
- DONE: hold PC and InstrCount. Start=1 → RUN with a new start address and counter cleared, as from IDLE. Stall is ignored in DONE.
- InstrCount saturates at 2^CNT_W−1; it does not wrap.
- Offset arithmetic: sign-extend the 11-bit LutOut to max(PC_W,11) bits, add, then keep the low PC_W bits. An offset of 0 is a self-loop.
- Halt and a taken branch in the same cycle: halt wins; no branch.

## Timing
- ProgCtr, Running, Done and InstrCount are registered. Each updates one cycle after the qualifying input edge.
- LutIndex→LutOut path is combinational within one cycle; the next-PC adder lies on that path.
- Start→first valid ProgCtr: 1 cycle. Running rises in the same cycle as ProgCtr=START.
- Done rises the cycle after Halt is sampled and stays high until a Start or a reset.
- Reset mid-RUN: next edge forces IDLE state, values regardless of Stall/Start/Halt. Reset has priority over everything.
- No combinational path from any input to ProgCtr/Running/Done/InstrCount.

## Structure
- Package pc_seq_pkg contains:
  - state enum (IDLE, RUN, DONE);
  - default PC_W/CNT_W constants;
  - the start-address defaults.
- One sub-module, instr_counter: a saturating counter with clear and enable. The FSM and PC register stay in the top level.
- The lookup table is instantiated by the parent and is not inside this block.

## Test plan
- Reset/start: Reset=0 two cycles → ProgCtr=0, Done=0, Running=0. Start=1 with ProgSel=2 → next cycle ProgCtr=512, Running=1, InstrCount=0.
- Sequential and stall: from PC=512, run 5 cycles with Stall high in cycle 3 → PC=516, InstrCount=4.
- Branch backward with wrap: PC=5, BranchEn=Taken=1, LutOut=−370 → PC=(5−370) mod 1024=659. Taken=0 → PC=6.
- Halt vs. branch: Halt=1 with BranchEn=Taken=1, LutOut=1, at PC=100 → DONE, PC=100, Done=1. Start during DONE with ProgSel=1 → PC=256, counter cleared.
- Saturation: CNT_W=4, run 20 unstalled cycles → InstrCount=15.
- Reset mid-run: Reset=0 while in RUN with Stall=1 and Start=1 → IDLE, PC=0, InstrCount=0 next cycle.
